// File: rtl/exec_ctrl.sv
// exec_ctrl: sequences one instruction at a time through fetch, issue and
// wait-for-completion, retiring on the required done pulses or timing out.
module exec_ctrl #(
    parameter int FETCH_LAT = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt_req,
    input  logic [31:0] op,
    input  logic        jump_finish,
    input  logic        write_finish,
    input  logic        load_finish,
    input  logic        store_finish,
    input  logic        uart_send_done,
    output logic        fetch_en,
    output logic        d_valid,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] err_op,
    output logic [31:0] icount
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_ERR} state_t;

    localparam logic [3:0] FETCH_LAST   = 4'(FETCH_LAT - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Done vector bit order: {uart, store, load, write, jump}
    localparam logic [4:0] D_JUMP  = 5'b00001;
    localparam logic [4:0] D_WRITE = 5'b00010;
    localparam logic [4:0] D_LOAD  = 5'b00100;
    localparam logic [4:0] D_STORE = 5'b01000;
    localparam logic [4:0] D_UART  = 5'b10000;

    state_t      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [4:0]  mask_q, mask_d;
    logic [4:0]  flags_q, flags_d;
    logic [31:0] op_q, op_d;
    logic [31:0] err_op_q, err_op_d;
    logic [31:0] icount_q, icount_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic [4:0]  done_in;
    logic [4:0]  mask_dec;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        retire;
    logic        timeout;

    assign done_in = {uart_send_done, store_finish, load_finish, write_finish, jump_finish};
    assign opcode  = op[31:26];
    assign func    = op[5:0];
    assign retire  = (state_q == S_WAIT) && (((flags_q | done_in) & mask_q) == mask_q);
    assign timeout = (state_q == S_WAIT) && !retire && (tcnt_q == TIMEOUT_LAST);

    // Recognised set: SPECIAL, J/JAL, BEQ/BNE, ALU immediates 0x08-0x0F, COP1,
    // loads, stores, SWC2, OUT. Anything else needs only jump_finish.
    always_comb begin
        mask_dec = D_JUMP;
        case (opcode)
            6'h23, 6'h31: mask_dec = D_JUMP | D_LOAD | D_WRITE;
            6'h2B, 6'h39: mask_dec = D_JUMP | D_STORE;
            6'h3A:        mask_dec = D_JUMP | D_UART;
            6'h02, 6'h04, 6'h05, 6'h3F: mask_dec = D_JUMP;
            6'h00:        mask_dec = (func == 6'h08) ? D_JUMP : (D_JUMP | D_WRITE);
            6'h11:        mask_dec = (func == 6'h10 || func == 6'h11) ? D_JUMP : (D_JUMP | D_WRITE);
            6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:  mask_dec = D_JUMP | D_WRITE;
            default:      mask_dec = D_JUMP;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            tcnt_q   <= '0;
            mask_q   <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            err_op_q <= '0;
            icount_q <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            tcnt_q   <= tcnt_d;
            mask_q   <= mask_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            err_op_q <= err_op_d;
            icount_q <= icount_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (fcnt_q == FETCH_LAST) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (retire)       state_d = halt_req ? S_IDLE : S_FETCH;
                else if (timeout) state_d = S_ERR;
            end
            S_ERR:   if (start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Retire takes priority over timeout, so a late final pulse still counts.
    always_comb begin
        fcnt_d   = (state_q == S_FETCH) ? fcnt_q + 4'd1 : 4'd0;
        tcnt_d   = tcnt_q;
        mask_d   = mask_q;
        flags_d  = flags_q;
        op_d     = op_q;
        err_op_d = err_op_q;
        icount_d = icount_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (start) halted_d = 1'b0;
            S_ISSUE: begin
                op_d    = op;
                mask_d  = mask_dec;
                flags_d = '0;
                tcnt_d  = '0;
            end
            S_WAIT: begin
                flags_d = flags_q | done_in;
                if (retire) begin
                    icount_d = icount_q + 32'd1;
                    halted_d = halt_req;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (timeout) begin
                        err_d    = 1'b1;
                        err_op_d = op_q;
                    end
                end
            end
            S_ERR: if (start) err_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == S_FETCH) && (fcnt_q == 4'd0);
        d_valid  = (state_q == S_ISSUE);
        busy     = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    end

    assign halted = halted_q;
    assign err    = err_q;
    assign err_op = err_op_q;
    assign icount = icount_q;

endmodule
